mem_wb: RTL and testbench

Pipeline register between the MEM and WB stages of the five-stage pipelined MIPS core. It captures the data-memory read word, the ALU result, the destination register number and the two write-back control bits on each rising clock edge. It presents them to the write-back mux and register file, and to the forwarding unit, for the next cycle.

---
 rtl/mem_wb.sv | 102 ++++++++++
 tb/tb_mem_wb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb
//
// MEM/WB pipeline register of the five-stage MIPS core. Every rising clock
// edge captures the data-memory read word, the ALU result, the destination
// register number and the two write-back control bits. These values then
// feed the write-back mux, the register file and the forwarding unit for the
// following cycle. This is a pure register stage: no input reaches an output
// combinationally, and there is no enable or stall.
//
// Reset (rst, asynchronous, active-low) clears every output at once. The
// all-zero state is a bubble: with Regwriteout2 = 0, the register file is
// not written.
//
// Parameters:
//   DATA_W      width of the memory-read and ALU-result paths
//   REG_ADDR_W  width of the destination register number
//
// Ports:
//   clk           in   pipeline clock, rising-edge capture
//   rst           in   asynchronous reset, active-low
//   memrdatain    in   word read from data memory
//   ALUresultin   in   ALU result / address carried through MEM
//   rt_rddin      in   destination register number (rt or rd)
//   MemtoRegin2   in   WB mux select (1 = memory data, 0 = ALU result)
//   Regwritein2   in   register-file write enable
//   memrdataout   out  registered memrdatain
//   ALUresultout  out  registered ALUresultin
//   rt_rddout     out  registered rt_rddin
//   MemtoRegout2  out  registered MemtoRegin2
//   Regwriteout2  out  registered Regwritein2 (see macro below)
//
// Build option:
//   MEM_WB_ZERO_DEST_SUPPRESS_EN
//     When defined, a write aimed at register 0 is dropped at capture time.
//     Regwriteout2 is then registered as 0 whenever rt_rddin == 0, so the
//     forwarding unit never sees $zero as a producer. When undefined,
//     Regwriteout2 is a plain copy of Regwritein2.
// -----------------------------------------------------------------------------
module mem_wb #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     memrdatain,
   input  logic [DATA_W-1:0]     ALUresultin,
   input  logic [REG_ADDR_W-1:0] rt_rddin,
   input  logic                  MemtoRegin2,
   input  logic                  Regwritein2,
   output logic [DATA_W-1:0]     memrdataout,
   output logic [DATA_W-1:0]     ALUresultout,
   output logic [REG_ADDR_W-1:0] rt_rddout,
   output logic                  MemtoRegout2,
   output logic                  Regwriteout2
);

   // Write enable as it should leave the stage, given the destination.
   function automatic logic wb_write_en(input logic [REG_ADDR_W-1:0] dest,
                                        input logic                  wr_en);
`ifdef MEM_WB_ZERO_DEST_SUPPRESS_EN
      // $zero is hard-wired; a write to it must not look like a producer.
      return wr_en & (dest != '0);
`else
      // Unused when suppression is off; reference it so every build stays
      // free of unused-argument warnings.
      return wr_en | (1'b0 & (&dest));
`endif
   endfunction

   logic [DATA_W-1:0]     mem_rdata_p1;
   logic [DATA_W-1:0]     alu_result_p1;
   logic [REG_ADDR_W-1:0] dest_reg_p1;
   logic                  mem_to_reg_p1;
   logic                  reg_write_p1;

   // ---- MEM -> WB boundary -------------------------------------------------
   // The data fields are cleared too, so a reset yields a clean bubble on
   // every output rather than stale data behind a zero write enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_rdata_p1  <= '0;
         alu_result_p1 <= '0;
         dest_reg_p1   <= '0;
         mem_to_reg_p1 <= 1'b0;
         reg_write_p1  <= 1'b0;
      end else begin
         mem_rdata_p1  <= memrdatain;
         alu_result_p1 <= ALUresultin;
         dest_reg_p1   <= rt_rddin;
         mem_to_reg_p1 <= MemtoRegin2;
         reg_write_p1  <= wb_write_en(rt_rddin, Regwritein2);
      end
   end

   assign memrdataout  = mem_rdata_p1;
   assign ALUresultout = alu_result_p1;
   assign rt_rddout    = dest_reg_p1;
   assign MemtoRegout2 = mem_to_reg_p1;
   assign Regwriteout2 = reg_write_p1;

endmodule

// File: tb/tb_mem_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_wb
//
// Self-checking bench for mem_wb. Each stimulus set is pushed to a scoreboard
// queue as it is driven, and the set is popped and compared after the edge
// that should capture it. Outputs are sampled 1 ns after the rising edge or
// on the falling edge. Honours MEM_WB_ZERO_DEST_SUPPRESS_EN in its model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_wb;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [DATA_W-1:0]     mem;
      logic [DATA_W-1:0]     alu;
      logic [REG_ADDR_W-1:0] rd;
      logic                  m2r;
      logic                  rw;
   } wb_t;

   logic                  clk;
   logic                  rst;
   logic [DATA_W-1:0]     memrdatain;
   logic [DATA_W-1:0]     ALUresultin;
   logic [REG_ADDR_W-1:0] rt_rddin;
   logic                  MemtoRegin2;
   logic                  Regwritein2;
   logic [DATA_W-1:0]     memrdataout;
   logic [DATA_W-1:0]     ALUresultout;
   logic [REG_ADDR_W-1:0] rt_rddout;
   logic                  MemtoRegout2;
   logic                  Regwriteout2;

   wb_t obs;
   assign obs = {memrdataout, ALUresultout, rt_rddout, MemtoRegout2, Regwriteout2};

   int  checks   = 0;
   int  failures = 0;
   wb_t exp_q[$];

   mem_wb #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .memrdatain   (memrdatain),
      .ALUresultin  (ALUresultin),
      .rt_rddin     (rt_rddin),
      .MemtoRegin2  (MemtoRegin2),
      .Regwritein2  (Regwritein2),
      .memrdataout  (memrdataout),
      .ALUresultout (ALUresultout),
      .rt_rddout    (rt_rddout),
      .MemtoRegout2 (MemtoRegout2),
      .Regwriteout2 (Regwriteout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected registered value for a given input set.
   function automatic wb_t model(input wb_t v);
      wb_t r = v;
`ifdef MEM_WB_ZERO_DEST_SUPPRESS_EN
      if (v.rd == '0) r.rw = 1'b0;
`endif
      return r;
   endfunction

   function automatic wb_t rand_set();
      wb_t r;
      r.mem = $urandom;
      r.alu = $urandom;
      r.rd  = REG_ADDR_W'($urandom_range(0, 31));
      r.m2r = 1'($urandom_range(0, 1));
      r.rw  = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic apply(input wb_t v);
      memrdatain  = v.mem;
      ALUresultin = v.alu;
      rt_rddin    = v.rd;
      MemtoRegin2 = v.m2r;
      Regwritein2 = v.rw;
   endtask

   // Drive a set and record what it should produce after the next edge.
   task automatic drive(input wb_t v);
      apply(v);
      exp_q.push_back(model(v));
   endtask

   task automatic test_reset();
      rst = 1'b0;
      apply(rand_set());
      #1;
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL reset_initial got=%h want=0", obs);
      end
      for (int i = 0; i < 10; i++) begin
         #3 apply(rand_set());
         @(posedge clk); #1;
         checks++;
         if (obs !== '0) begin
            failures++;
            $display("FAIL reset_hold[%0d] got=%h want=0", i, obs);
         end
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_normal_capture();
      wb_t v, e;
      v = '{mem: 32'd1234, alu: 32'd5678, rd: 5'd10, m2r: 1'b1, rw: 1'b1};
      drive(v);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL normal_capture got=%h want=%h", obs, e);
      end
      @(negedge clk);
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL normal_hold got=%h want=%h", obs, e);
      end
   endtask

   task automatic test_mid_reset();
      wb_t e;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL midreset_async got=%h want=0", obs);
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL midreset_hold got=%h want=0", obs);
      end
      @(negedge clk);
      rst = 1'b1;
      // Inputs still carry the previous set; the next edge reloads them.
      exp_q.push_back(model({memrdatain, ALUresultin, rt_rddin, MemtoRegin2, Regwritein2}));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL midreset_reload got=%h want=%h", obs, e);
      end
   endtask

   task automatic test_second_load();
      wb_t v, e;
      @(negedge clk);
      v = '{mem: 32'd8765, alu: 32'd4321, rd: 5'd5, m2r: 1'b0, rw: 1'b0};
      drive(v);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL second_load got=%h want=%h", obs, e);
      end
      #2 apply('{mem: 32'hDEADBEEF, alu: 32'hCAFEF00D, rd: 5'd31, m2r: 1'b1, rw: 1'b1});
      @(negedge clk);
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL second_input_change got=%h want=%h", obs, e);
      end
   endtask

   task automatic test_back_to_back();
      wb_t vs[4];
      wb_t e;
      vs[0] = '{mem: 32'h0000_0001, alu: 32'h1000_0000, rd: 5'd1,  m2r: 1'b1, rw: 1'b1};
      vs[1] = '{mem: 32'hFFFF_FFFF, alu: 32'h0000_0000, rd: 5'd31, m2r: 1'b0, rw: 1'b1};
      vs[2] = '{mem: 32'hA5A5_A5A5, alu: 32'h5A5A_5A5A, rd: 5'd17, m2r: 1'b1, rw: 1'b0};
      vs[3] = '{mem: 32'h1357_9BDF, alu: 32'h2468_ACE0, rd: 5'd8,  m2r: 1'b0, rw: 1'b1};
      drive(vs[0]);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b2b_underflow[%0d] got=empty want=entry", i);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
               failures++;
               $display("FAIL b2b[%0d] got=%h want=%h", i, obs, e);
            end
         end
         if (i < 3) drive(vs[i+1]);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_leftover got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_zero_dest();
      wb_t v, e;
      logic want_rw;
`ifdef MEM_WB_ZERO_DEST_SUPPRESS_EN
      want_rw = 1'b0;
`else
      want_rw = 1'b1;
`endif
      @(negedge clk);
      v = '{mem: 32'h0000_00AA, alu: 32'h0000_00BB, rd: 5'd0, m2r: 1'b0, rw: 1'b1};
      drive(v);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL zero_dest_all got=%h want=%h", obs, e);
      end
      checks++;
      if (Regwriteout2 !== want_rw) begin
         failures++;
         $display("FAIL zero_dest_rw got=%b want=%b", Regwriteout2, want_rw);
      end
      checks++;
      if (rt_rddout !== 5'd0) begin
         failures++;
         $display("FAIL zero_dest_rd got=%0d want=0", rt_rddout);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_normal_capture();
      test_mid_reset();
      test_second_load();
      test_back_to_back();
      test_zero_dest();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
